branch_resolver: RTL and testbench

- Consumer side of the NZP condition-code register in the LC-3 datapath.
- Accepts a control-flow instruction (BR, JMP/RET, JSR/JSRR) together with the latched N/Z/P flags, the incremented PC and the BaseR value.
- Evaluates BEN, computes the target and issues a held redirect to fetch via a valid/ack handshake.
- Emits the R7 link write for subroutine calls and keeps taken/not-taken statistics counters.

---
 rtl/branch_resolver.sv | 142 ++++++++++++++
 tb/tb_branch_resolver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: resolves LC-3 control-flow instructions (BR, JMP/RET,
// JSR/JSRR) against the latched NZP flags. It issues a held redirect to
// fetch over a valid/ack handshake, writes the R7 link for calls, and keeps
// taken / not-taken statistics.
module branch_resolver #(
  parameter int CNT_W   = 16,
  parameter bit CNT_SAT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ir_valid,
  output logic             ir_ready,
  input  logic [15:0]      ir,
  input  logic [15:0]      pc,
  input  logic [2:0]       nzp,
  input  logic [15:0]      base_r,
  output logic             ben,
  output logic             redir_valid,
  output logic [15:0]      redir_pc,
  input  logic             redir_ack,
  output logic             link_we,
  output logic [15:0]      link_data,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic [15:0] pc_reg;
  logic [2:0]  nzp_reg;
  logic [15:0] base_reg;

  logic        taken_next;
  logic [15:0] target_next;

  // Counter step: hold at all-ones when saturating, otherwise wrap naturally.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (CNT_SAT && (&c))
      return c;
    return c + 1'b1;
  endfunction

  assign ir_ready = (state_reg == S_IDLE);

  // Branch-enable and target decode from the captured instruction.
  always_comb begin
    taken_next  = 1'b0;
    target_next = 16'h0000;
    case (ir_reg[15:12])
      OP_BR: begin
        taken_next  = |(ir_reg[11:9] & nzp_reg);
        target_next = pc_reg + {{7{ir_reg[8]}}, ir_reg[8:0]};
      end
      OP_JMP: begin
        taken_next  = 1'b1;
        target_next = base_reg;
      end
      OP_JSR: begin
        taken_next  = 1'b1;
        // JSRR uses the captured base, so JSRR R7 jumps to the old R7.
        target_next = ir_reg[11] ? (pc_reg + {{5{ir_reg[10]}}, ir_reg[10:0]})
                                 : base_reg;
      end
      default: begin
        taken_next  = 1'b0;
        target_next = 16'h0000;
      end
    endcase
  end

  // Control FSM with registered outputs and statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      ir_reg      <= 16'h0000;
      pc_reg      <= 16'h0000;
      nzp_reg     <= 3'b000;
      base_reg    <= 16'h0000;
      ben         <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= 16'h0000;
      link_we     <= 1'b0;
      link_data   <= 16'h0000;
      done        <= 1'b0;
      taken_cnt   <= '0;
      nt_cnt      <= '0;
    end else begin
      done    <= 1'b0;
      link_we <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ir_valid) begin
            ir_reg    <= ir;
            pc_reg    <= pc;
            nzp_reg   <= nzp;
            base_reg  <= base_r;
            state_reg <= S_EVAL;
            // Link strobe is decoded at capture so it is high exactly
            // during the EVAL cycle while still coming from a flop.
            if (ir[15:12] == OP_JSR) begin
              link_we   <= 1'b1;
              link_data <= pc;
            end
          end
        end
        S_EVAL: begin
          ben <= taken_next;
          if (taken_next) begin
            redir_pc    <= target_next;
            redir_valid <= 1'b1;
            state_reg   <= S_REDIRECT;
          end else begin
            done      <= 1'b1;
            nt_cnt    <= cnt_inc(nt_cnt);
            state_reg <= S_IDLE;
          end
        end
        S_REDIRECT: begin
          if (redir_ack) begin
            redir_valid <= 1'b0;
            done        <= 1'b1;
            taken_cnt   <= cnt_inc(taken_cnt);
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed test-plan cases plus randomized
// instructions checked against an instruction-level reference model.
module tb_branch_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] pc;
  logic [2:0]  nzp;
  logic [15:0] base_r;
  logic        redir_ack;

  logic        ir_ready, ben, redir_valid, link_we, done;
  logic [15:0] redir_pc, link_data, taken_cnt, nt_cnt;

  logic        s_ir_ready, s_ben, s_redir_valid, s_link_we, s_done;
  logic [15:0] s_redir_pc, s_link_data;
  logic [1:0]  s_taken_cnt, s_nt_cnt;

  logic        w_ir_ready, w_ben, w_redir_valid, w_link_we, w_done;
  logic [15:0] w_redir_pc, w_link_data;
  logic [1:0]  w_taken_cnt, w_nt_cnt;

  int tests = 0;
  int fails = 0;
  int m_taken = 0;
  int m_nt = 0;

  branch_resolver #(.CNT_W(16), .CNT_SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir(ir), .pc(pc), .nzp(nzp), .base_r(base_r), .ben(ben),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ack(redir_ack),
    .link_we(link_we), .link_data(link_data), .done(done),
    .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  branch_resolver #(.CNT_W(2), .CNT_SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_ready(s_ir_ready),
    .ir(ir), .pc(pc), .nzp(nzp), .base_r(base_r), .ben(s_ben),
    .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .redir_ack(redir_ack),
    .link_we(s_link_we), .link_data(s_link_data), .done(s_done),
    .taken_cnt(s_taken_cnt), .nt_cnt(s_nt_cnt)
  );

  branch_resolver #(.CNT_W(2), .CNT_SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_ready(w_ir_ready),
    .ir(ir), .pc(pc), .nzp(nzp), .base_r(base_r), .ben(w_ben),
    .redir_valid(w_redir_valid), .redir_pc(w_redir_pc), .redir_ack(redir_ack),
    .link_we(w_link_we), .link_data(w_link_data), .done(w_done),
    .taken_cnt(w_taken_cnt), .nt_cnt(w_nt_cnt)
  );

  // Instruction-level reference: what the LC-3 does with this instruction.
  function automatic void model(input logic [15:0] i, input logic [15:0] p,
                                input logic [2:0] cc, input logic [15:0] b,
                                output bit tk, output logic [15:0] tgt,
                                output bit lk);
    int off;
    tk = 1'b0; tgt = 16'h0000; lk = 1'b0;
    case (i[15:12])
      4'b0000: begin
        off = int'(i[8:0]);
        if (off > 255) off = off - 512;
        tk  = ((i[11:9] & cc) != 3'b000);
        tgt = 16'(int'(p) + off);
      end
      4'b1100: begin
        tk = 1'b1; tgt = b;
      end
      4'b0100: begin
        tk = 1'b1; lk = 1'b1;
        if (i[11]) begin
          off = int'(i[10:0]);
          if (off > 1023) off = off - 2048;
          tgt = 16'(int'(p) + off);
        end else begin
          tgt = b;
        end
      end
      default: begin
        tk = 1'b0;
      end
    endcase
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_taken = 0;
    m_nt = 0;
  endtask

  // Issue one instruction, follow it to retirement, check every step inline.
  task automatic run_instr(input logic [15:0] i, input logic [15:0] p,
                           input logic [2:0] cc, input logic [15:0] b,
                           input int dly);
    bit tk, lk;
    logic [15:0] tgt;
    int w;
    model(i, p, cc, b, tk, tgt, lk);
    w = 0;
    while (!ir_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (ir_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout: ir_ready=%b required 1", ir_ready);
      return;
    end
    ir_valid = 1'b1; ir = i; pc = p; nzp = cc; base_r = b;
    @(negedge clk);
    ir_valid = 1'b0;
    ir = 16'($urandom); pc = 16'($urandom); nzp = 3'($urandom); base_r = 16'($urandom);
    tests++;
    if (ir_ready !== 1'b0) begin
      fails++; $display("FAIL eval_ready: got %b required 0", ir_ready);
    end
    tests++;
    if (link_we !== lk) begin
      fails++; $display("FAIL link_we ir=%h: got %b required %b", i, link_we, lk);
    end
    if (lk) begin
      tests++;
      if (link_data !== p) begin
        fails++; $display("FAIL link_data ir=%h: got %h required %h", i, link_data, p);
      end
    end
    @(negedge clk);
    tests++;
    if (ben !== tk || link_we !== 1'b0) begin
      fails++; $display("FAIL ben ir=%h: ben=%b link_we=%b required ben=%b link_we=0", i, ben, link_we, tk);
    end
    if (tk) begin
      tests++;
      if (redir_valid !== 1'b1 || redir_pc !== tgt || done !== 1'b0) begin
        fails++;
        $display("FAIL redirect ir=%h: valid=%b pc=%h done=%b required 1 %h 0", i, redir_valid, redir_pc, done, tgt);
      end
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        tests++;
        if (redir_valid !== 1'b1 || redir_pc !== tgt || done !== 1'b0) begin
          fails++;
          $display("FAIL redirect_hold ir=%h: valid=%b pc=%h required 1 %h", i, redir_valid, redir_pc, tgt);
        end
      end
      redir_ack = 1'b1;
      @(negedge clk);
      redir_ack = 1'b0;
      m_taken++;
      tests++;
      if (redir_valid !== 1'b0 || done !== 1'b1 || taken_cnt !== 16'(m_taken) || ir_ready !== 1'b1) begin
        fails++;
        $display("FAIL ack_retire ir=%h: valid=%b done=%b taken_cnt=%0d ready=%b required 0 1 %0d 1", i, redir_valid, done, taken_cnt, ir_ready, m_taken);
      end
    end else begin
      m_nt++;
      tests++;
      if (redir_valid !== 1'b0 || done !== 1'b1 || nt_cnt !== 16'(m_nt) || ir_ready !== 1'b1) begin
        fails++;
        $display("FAIL nt_retire ir=%h: valid=%b done=%b nt_cnt=%0d ready=%b required 0 1 %0d 1", i, redir_valid, done, nt_cnt, ir_ready, m_nt);
      end
    end
    $display("[TB] ir=%h pc=%h nzp=%b base=%h taken=%0d target=%h link=%0d ack_delay=%0d", i, p, cc, b, tk, tgt, lk, dly);
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_valid = 1'b0; redir_ack = 1'b0;
    ir = 16'h0; pc = 16'h0; nzp = 3'b0; base_r = 16'h0;
    repeat (2) @(negedge clk);
    tests++;
    if (ir_ready !== 1'b1 || ben !== 1'b0 || redir_valid !== 1'b0 || redir_pc !== 16'h0 ||
        link_we !== 1'b0 || link_data !== 16'h0 || done !== 1'b0 || taken_cnt !== 16'h0 || nt_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b ben=%b rv=%b rpc=%h lwe=%b ld=%h done=%b tc=%0d nc=%0d", ir_ready, ben, redir_valid, redir_pc, link_we, link_data, done, taken_cnt, nt_cnt);
    end
    reset = 1'b0;
    m_taken = 0; m_nt = 0;
  endtask

  task automatic test_branch();
    run_instr(16'h0405, 16'h3001, 3'b010, 16'h1234, 3);
    run_instr(16'h09FF, 16'h3001, 3'b001, 16'h0000, 0);
    run_instr(16'h09FF, 16'h0000, 3'b100, 16'h0000, 1);
    run_instr(16'h0E07, 16'h2000, 3'b000, 16'h0000, 0);
    run_instr(16'h0E07, 16'h2000, 3'b001, 16'h0000, 0);
    run_instr(16'h0107, 16'h2000, 3'b111, 16'h0000, 0);
  endtask

  task automatic test_jump_link();
    run_instr(16'h41C0, 16'h3010, 3'b000, 16'h4000, 2);
    run_instr(16'hC1C0, 16'h3020, 3'b010, 16'h3011, 0);
    run_instr(16'h4BFF, 16'h3000, 3'b100, 16'h5555, 1);
    run_instr(16'h1234, 16'h3000, 3'b111, 16'h5555, 0);
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    redir_ack = 1'b1;
    repeat (2) @(negedge clk);
    redir_ack = 1'b0;
    tests++;
    if (redir_valid !== 1'b0 || done !== 1'b0 || taken_cnt !== 16'(m_taken)) begin
      fails++;
      $display("FAIL stray_ack: valid=%b done=%b taken_cnt=%0d required 0 0 %0d", redir_valid, done, taken_cnt, m_taken);
    end
  endtask

  task automatic test_reset_in_redirect();
    @(negedge clk);
    ir_valid = 1'b1; ir = 16'h0405; pc = 16'h3001; nzp = 3'b010; base_r = 16'h0;
    @(negedge clk);
    ir_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (redir_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset_redirect: valid=%b required 1", redir_valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (redir_valid !== 1'b0 || ir_ready !== 1'b1 || ben !== 1'b0 || taken_cnt !== 16'h0 || nt_cnt !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: valid=%b ready=%b ben=%b tc=%0d nc=%0d required 0 1 0 0 0", redir_valid, ir_ready, ben, taken_cnt, nt_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    m_taken = 0; m_nt = 0;
    redir_ack = 1'b1;
    @(negedge clk);
    redir_ack = 1'b0;
    tests++;
    if (taken_cnt !== 16'h0 || done !== 1'b0 || redir_valid !== 1'b0) begin
      fails++;
      $display("FAIL ack_after_reset: tc=%0d done=%b valid=%b required 0 0 0", taken_cnt, done, redir_valid);
    end
    $display("[TB] reset during redirect, later ack ignored");
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int n = 0; n < 5; n++)
      run_instr(16'h0000, 16'($urandom), 3'($urandom), 16'($urandom), 0);
    tests++;
    if (s_nt_cnt !== 2'd3) begin
      fails++; $display("FAIL sat_counter: got %0d required 3", s_nt_cnt);
    end
    tests++;
    if (w_nt_cnt !== 2'd1) begin
      fails++; $display("FAIL wrap_counter: got %0d required 1", w_nt_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] i;
    for (int n = 0; n < 40; n++) begin
      i = 16'($urandom);
      case ($urandom_range(0, 3))
        0: i[15:12] = 4'b0000;
        1: i[15:12] = 4'b1100;
        2: i[15:12] = 4'b0100;
        default: ;
      endcase
      run_instr(i, 16'($urandom), 3'($urandom), 16'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_link();
    test_stray_ack();
    test_reset_in_redirect();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
